// File: rtl/data_sram_like_slave_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_sram_like_slave_if
// Initiator-side SRAM-like request/response bus plus the synchronous SRAM port.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface data_sram_like_slave_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, sram_rdata,
    output data_rdata, data_addr_ok, data_data_ok,
           sram_en, sram_wen, sram_addr, sram_wdata
  );

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, sram_rdata,
    input  data_rdata, data_addr_ok, data_data_ok,
           sram_en, sram_wen, sram_addr, sram_wdata
  );
endinterface
`default_nettype wire

// File: rtl/data_sram_like_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// data_sram_like_slave
// SRAM-like slave: two-deep in-order request queue in front of a synchronous SRAM.
// Revision: 1.0
// ----------------------------------------------------------------------------
module data_sram_like_slave #(
  parameter int LATENCY = 1,
  parameter int DEPTH   = 2
) (
  input logic                   clk,
  input logic                   resetn,
  data_sram_like_slave_if.slave bus
);

  localparam logic [2:0] c_lat   = 3'(LATENCY);
  localparam logic [1:0] c_depth = 2'(DEPTH);

  logic [1:0]  r_count;
  logic        r_head;
  logic        r_wr   [2];
  logic [2:0]  r_age  [2];
  logic [31:0] r_data [2];
  logic        r_dv   [2];

  logic        w_accept;
  logic        w_pop;
  logic        w_tail;
  logic [3:0]  w_wen;
  logic [31:0] w_head_rd;

  // Occupancy is sampled before any same-cycle pop, so a full queue never passes through.
  assign bus.data_addr_ok = bus.data_req & (r_count < c_depth) & ~resetn;
  assign w_accept         = bus.data_req & bus.data_addr_ok;
  assign w_tail           = r_head ^ r_count[0];
  assign w_pop            = (r_count != 2'd0) & (r_age[r_head] >= (c_lat - 3'd1)) & ~resetn;

  assign bus.sram_en    = w_accept;
  assign bus.sram_wen   = w_wen;
  assign bus.sram_addr  = {bus.data_addr[31:2], 2'b00};
  assign bus.sram_wdata = bus.data_wdata;

  always_comb begin
    w_wen = 4'b0000;
    if (w_accept && bus.data_wr) begin
      case (bus.data_size)
        2'b00:   w_wen = 4'b0001 << bus.data_addr[1:0];
        2'b01:   w_wen = bus.data_addr[1] ? 4'b1100 : 4'b0011;
        2'b10:   w_wen = 4'b1111;
        default: w_wen = 4'b0000;
      endcase
    end
  end

  // Single-cycle latency completes while the SRAM output is still live, so bypass it.
  assign w_head_rd = (c_lat == 3'd1) ? bus.sram_rdata
                                     : (r_dv[r_head] ? r_data[r_head] : 32'd0);

  assign bus.data_data_ok = w_pop;
  assign bus.data_rdata   = (w_pop && !r_wr[r_head]) ? w_head_rd : 32'd0;

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_count <= 2'd0;
      r_head  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        r_wr[i]   <= 1'b0;
        r_age[i]  <= 3'd0;
        r_data[i] <= 32'd0;
        r_dv[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (r_age[i] < c_lat) begin
          r_age[i] <= r_age[i] + 3'd1;
        end
        if (r_age[i] == 3'd0) begin
          r_data[i] <= bus.sram_rdata;
          r_dv[i]   <= 1'b1;
        end
      end
      // The tail slot is always free when accepting, so these override the loop above.
      if (w_accept) begin
        r_wr[w_tail]  <= bus.data_wr;
        r_age[w_tail] <= 3'd0;
        r_dv[w_tail]  <= 1'b0;
      end
      r_count <= r_count + 2'(w_accept) - 2'(w_pop);
      r_head  <= r_head ^ w_pop;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_sram_like_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_data_sram_like_slave
// Drives LATENCY=1 and LATENCY=3 instances with one request stream against a queue model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_data_sram_like_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int lat [2] = '{1, 3};

  typedef struct {
    int          d;
    logic        wr;
    logic [31:0] data;
    int          due;
  } pend_t;
  pend_t pq[$];

  logic [7:0]  ref_mem [2][1024];
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];

  data_sram_like_slave_if bus1 ();
  data_sram_like_slave_if bus3 ();

  data_sram_like_slave #(.LATENCY(1), .DEPTH(2)) dut1 (.clk(clk), .resetn(rst), .bus(bus1.slave));
  data_sram_like_slave #(.LATENCY(3), .DEPTH(2)) dut3 (.clk(clk), .resetn(rst), .bus(bus3.slave));

  always #5 clk = ~clk;

  assign bus1.data_req = req;   assign bus3.data_req = req;
  assign bus1.data_wr = wr;     assign bus3.data_wr = wr;
  assign bus1.data_size = size; assign bus3.data_size = size;
  assign bus1.data_addr = addr; assign bus3.data_addr = addr;
  assign bus1.data_wdata = wdata; assign bus3.data_wdata = wdata;

  logic [1:0]  aok, dok, en;
  logic [3:0]  wen [2];
  logic [31:0] rd [2], sa [2], sw [2];
  assign aok = {bus3.data_addr_ok, bus1.data_addr_ok};
  assign dok = {bus3.data_data_ok, bus1.data_data_ok};
  assign en  = {bus3.sram_en, bus1.sram_en};
  assign wen[0] = bus1.sram_wen;  assign wen[1] = bus3.sram_wen;
  assign rd[0] = bus1.data_rdata; assign rd[1] = bus3.data_rdata;
  assign sa[0] = bus1.sram_addr;  assign sa[1] = bus3.sram_addr;
  assign sw[0] = bus1.sram_wdata; assign sw[1] = bus3.sram_wdata;

  // Synchronous SRAM environment: data appears one cycle after sram_en.
  always @(posedge clk) begin
    if (bus1.sram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus1.sram_wen[b]) mem1[bus1.sram_addr[9:2]][8*b +: 8] <= bus1.sram_wdata[8*b +: 8];
      bus1.sram_rdata <= mem1[bus1.sram_addr[9:2]];
    end
    if (bus3.sram_en) begin
      for (int b = 0; b < 4; b++)
        if (bus3.sram_wen[b]) mem3[bus3.sram_addr[9:2]][8*b +: 8] <= bus3.sram_wdata[8*b +: 8];
      bus3.sram_rdata <= mem3[bus3.sram_addr[9:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] byte_mask(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00:   return 4'(1 << a);
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      2'b10:   return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic set_req(input logic r, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] wd);
    req = r; wr = w; size = s; addr = a; wdata = wd;
  endtask

  // One clock: check both instances mid-cycle against the model, then advance.
  task automatic cycle();
    int          hi, n, base;
    logic        e_aok, e_dok;
    logic [3:0]  e_wen;
    logic [31:0] e_rd, word;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      hi = -1; n = 0;
      for (int i = 0; i < pq.size(); i++)
        if (pq[i].d == d) begin
          if (hi < 0) hi = i;
          n++;
        end
      e_aok = req && (n < 2) && !rst;
      e_dok = 1'b0;
      e_rd  = 32'd0;
      if (!rst && hi >= 0 && cyc >= pq[hi].due) begin
        e_dok = 1'b1;
        if (!pq[hi].wr) e_rd = pq[hi].data;
      end
      e_wen = (e_aok && wr) ? byte_mask(size, addr[1:0]) : 4'b0000;
      chk($sformatf("L%0d c%0d addr_ok", lat[d], cyc), 32'(aok[d]), 32'(e_aok));
      chk($sformatf("L%0d c%0d data_ok", lat[d], cyc), 32'(dok[d]), 32'(e_dok));
      chk($sformatf("L%0d c%0d rdata", lat[d], cyc), rd[d], e_rd);
      chk($sformatf("L%0d c%0d sram_en", lat[d], cyc), 32'(en[d]), 32'(e_aok));
      chk($sformatf("L%0d c%0d sram_wen", lat[d], cyc), 32'(wen[d]), 32'(e_wen));
      if (e_aok) begin
        chk($sformatf("L%0d c%0d sram_addr", lat[d], cyc), sa[d], {addr[31:2], 2'b00});
        chk($sformatf("L%0d c%0d sram_wdata", lat[d], cyc), sw[d], wdata);
      end
      if (e_dok) pq.delete(hi);
      if (e_aok) begin
        base = int'({addr[9:2], 2'b00});
        for (int b = 0; b < 4; b++) begin
          if (e_wen[b]) ref_mem[d][base + b] = wdata[8*b +: 8];
          word[8*b +: 8] = ref_mem[d][base + b];
        end
        pq.push_back('{d: d, wr: wr, data: word, due: cyc + lat[d]});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int k);
    set_req(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    for (int i = 0; i < k; i++) cycle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      ref_mem[0][i] = 8'h00;
      ref_mem[1][i] = 8'h00;
    end
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 32'd0;
      mem3[i] = 32'd0;
    end
    bus1.sram_rdata = 32'd0;
    bus3.sram_rdata = 32'd0;

    // Held in reset with a pending request: everything must stay quiet.
    @(posedge clk); #1;
    set_req(1'b1, 1'b1, 2'b10, 32'h100, 32'hDEADBEEF);
    cycle();
    cycle();

    // Word write accepted in the very first cycle out of reset.
    rst = 1'b0;
    cycle();
    idle(4);

    // Byte write into the top lane, then a word read of the same word.
    set_req(1'b1, 1'b1, 2'b00, 32'h103, 32'hAB000000);
    cycle();
    idle(4);
    set_req(1'b1, 1'b0, 2'b10, 32'h100, 32'd0);
    cycle();
    idle(1);
    chk("byte_lane_top", {24'd0, ref_mem[0][32'h103]}, 32'h000000AB);
    idle(3);

    // Back-to-back reads.
    set_req(1'b1, 1'b0, 2'b10, 32'h0, 32'd0); cycle();
    set_req(1'b1, 1'b0, 2'b10, 32'h4, 32'd0); cycle();
    set_req(1'b1, 1'b0, 2'b10, 32'h8, 32'd0); cycle();
    idle(5);

    // Request held high: the deeper instance must stall when full.
    set_req(1'b1, 1'b0, 2'b10, 32'h100, 32'd0);
    for (int i = 0; i < 7; i++) cycle();
    idle(5);

    // Halfword upper write and the unsupported size code.
    set_req(1'b1, 1'b1, 2'b01, 32'h102, 32'h12340000); cycle();
    idle(4);
    set_req(1'b1, 1'b1, 2'b11, 32'h200, 32'hFFFFFFFF); cycle();
    idle(4);
    set_req(1'b1, 1'b0, 2'b10, 32'h200, 32'd0); cycle();
    idle(4);

    // Randomised traffic, including misaligned addresses and size 11.
    for (int i = 0; i < 400; i++) begin
      set_req(($urandom_range(0, 9) < 6), 1'($urandom), 2'($urandom),
              $urandom, $urandom);
      cycle();
    end
    idle(5);

    // Asynchronous reset with two reads outstanding in the LATENCY=3 instance.
    set_req(1'b1, 1'b0, 2'b10, 32'h0, 32'd0); cycle();
    set_req(1'b1, 1'b0, 2'b10, 32'h4, 32'd0); cycle();
    set_req(1'b1, 1'b0, 2'b10, 32'h8, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("L%0d async addr_ok", lat[d]), 32'(aok[d]), 32'd0);
      chk($sformatf("L%0d async data_ok", lat[d]), 32'(dok[d]), 32'd0);
      chk($sformatf("L%0d async rdata", lat[d]), rd[d], 32'd0);
      chk($sformatf("L%0d async sram_en", lat[d]), 32'(en[d]), 32'd0);
      chk($sformatf("L%0d async sram_wen", lat[d]), 32'(wen[d]), 32'd0);
    end
    pq.delete();
    cycle();
    cycle();
    rst = 1'b0;
    set_req(1'b1, 1'b1, 2'b10, 32'h40, 32'hCAFEF00D);
    cycle();
    idle(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_sram_like_slave.md
DATA_SRAM_LIKE_SLAVE -- requirements
Module: data_sram_like_slave

Interface
REQ-001 SHALL have parameter LATENCY, default 1, meaning cycles from request accept to data_ok (legal 1..4).
REQ-002 SHALL have parameter DEPTH, default 2, meaning max outstanding accepted requests (fixed 2).
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port resetn  in  1  asynchronous, active-high reset (1 = in reset).
REQ-005 SHALL have port data_req  in  1  initiator request valid.
REQ-006 SHALL have port data_wr  in  1  1 = write, 0 = read.
REQ-007 SHALL have port data_size  in  2  00 byte, 01 halfword, 10 word.
REQ-008 SHALL have port data_addr  in  32  byte address.
REQ-009 SHALL have port data_wdata  in  32  write data, already lane-aligned by initiator.
REQ-010 SHALL have port data_rdata  out  32  read data, valid with data_ok.
REQ-011 SHALL have port data_addr_ok  out  1  request accepted this cycle.
REQ-012 SHALL have port data_data_ok  out  1  oldest outstanding request completes this cycle.
REQ-013 SHALL have ports sram_en out 1, sram_wen out 4, sram_addr out 32, sram_wdata out 32, sram_rdata in 32: synchronous SRAM, read data one cycle after sram_en.

Function
REQ-014 SHALL drive data_addr_ok = data_req & (outstanding count < DEPTH) & ~resetn; accept = data_req & data_addr_ok.
REQ-015 SHALL not let a same-cycle pop free a slot for a same-cycle accept (no pass-through when full).
REQ-016 SHALL, in accept cycle, drive sram_en=1, sram_addr={data_addr[31:2],2'b00}, sram_wdata=data_wdata; sram_en=0 otherwise.
REQ-017 SHALL drive sram_wen on accepted write: size 00 -> 4'b0001<<addr[1:0]; size 01 -> addr[1]?1100:0011; size 10 -> 1111; size 11 -> 0000; sram_wen=0000 on reads and when not accepting.
REQ-018 SHALL queue each accept as FIFO entry {wr, age counter=0, data, data_valid=0}.
REQ-019 SHALL capture sram_rdata into the entry on the edge one cycle after its accept, set data_valid.
REQ-020 SHALL increment each entry's age each cycle, saturating at LATENCY.
REQ-021 SHALL assert data_data_ok in cycle accept+LATENCY for head entry, strictly in accept order; only head may complete.
REQ-022 SHALL drive data_rdata: head read with LATENCY=1 -> sram_rdata bypass; head read LATENCY>1 -> captured data; writes and idle -> 32'd0.
REQ-023 SHALL pop head on data_data_ok; push+pop same cycle keeps count unchanged.
REQ-024 SHALL sustain one accept per cycle when LATENCY=1 (count never exceeds 1 with continuous data_req).
REQ-025 SHALL respond to misaligned or size-11 requests normally (no error signalling); alignment checking belongs to initiator.
REQ-026 SHALL ignore data_wr/size/addr/wdata when data_req=0.
REQ-027 SHALL have a combinational path only from data_req/request fields to data_addr_ok and sram_* ports, and from sram_rdata to data_rdata (LATENCY=1).

Reset
REQ-028 SHALL, while resetn=1, force data_addr_ok=0, data_data_ok=0, data_rdata=0, sram_en=0, sram_wen=0, queue empty, all ages 0.
REQ-029 SHALL discard in-flight requests on reset mid-operation; no data_ok for them after release.
REQ-030 SHALL accept a request in the first cycle after resetn deasserts.

Verification
REQ-031 Word write addr 0x100, wdata 0xDEADBEEF, LATENCY=1 -> addr_ok cycle T, sram_wen=1111, sram_addr=0x100; data_ok T+1, rdata=0.
REQ-032 Byte write addr 0x103 wdata 0xAB000000 then word read 0x100 (SRAM model) -> sram_wen=1000; read data_ok rdata=0xAB??????, upper byte 0xAB.
REQ-033 Back-to-back reads 0x0,0x4,0x8 with LATENCY=1 -> addr_ok three consecutive cycles, data_ok three consecutive cycles, in order.
REQ-034 LATENCY=3, data_req held high -> two accepts (T, T+1), addr_ok low T+2, data_ok T+3 then T+4, third accept T+4 earliest... verify not at T+3.
REQ-035 Halfword write addr 0x102 -> sram_wen=1100; size 11 write -> sram_wen=0000 yet data_ok still returned.
REQ-036 Assert resetn with two outstanding reads -> outputs zero immediately (asynchronous), no data_ok after release, new request accepted first cycle after release.
